// File: rtl/lsu_mem_stage_if.sv
// Operation encoding and the bundled execute-side, bus-side and writeback-side
// signals of the LSU memory stage. The DUT uses the slave view; the environment uses the master view.
package lsu_mem_pkg;
  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LBU = 3'd1,
    OP_LH  = 3'd2,
    OP_LHU = 3'd3,
    OP_LW  = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } instruction_type;
endpackage

interface lsu_mem_stage_if;
  import lsu_mem_pkg::*;

  // Execute-stage request
  logic            in_valid;
  logic            in_ready;
  instruction_type i;
  logic            read;
  logic [31:0]     read_address;
  logic [31:0]     write_address;
  logic [31:0]     DATA_wb;
  logic [3:0]      we_mem;
  logic [4:0]      rd;
  logic            flush;

  // Memory bus
  logic            mem_req;
  logic [31:0]     mem_addr;
  logic [3:0]      mem_we;
  logic [31:0]     mem_wdata;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [31:0]     mem_rdata;

  // Writeback and exception
  logic            wb_valid;
  logic            wb_we;
  logic [4:0]      wb_rd;
  logic [31:0]     wb_data;
  logic            misalign_exc;

  modport slave (
    input  in_valid, i, read, read_address, write_address, DATA_wb, we_mem, rd, flush,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output in_ready, mem_req, mem_addr, mem_we, mem_wdata,
    output wb_valid, wb_we, wb_rd, wb_data, misalign_exc
  );

  modport master (
    output in_valid, i, read, read_address, write_address, DATA_wb, we_mem, rd, flush,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  in_ready, mem_req, mem_addr, mem_we, mem_wdata,
    input  wb_valid, wb_we, wb_rd, wb_data, misalign_exc
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// LSU memory stage: one load/store in flight, IDLE -> REQ -> (WAIT) -> IDLE, all outputs registered.
// Define MISALIGN_CHECK_EN to trap misaligned halfword/word accesses instead of issuing them.
module lsu_mem_stage
  import lsu_mem_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  lsu_mem_stage_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_e;

  state_e          state_q;
  instruction_type op_q;
  logic            is_load_q;
  logic            flushed_q;
  logic [1:0]      off_q;
  logic [4:0]      rd_q;

  logic            mem_req_q;
  logic [31:0]     mem_addr_q;
  logic [3:0]      mem_we_q;
  logic [31:0]     mem_wdata_q;

  logic            wb_valid_q;
  logic            wb_we_q;
  logic [4:0]      wb_rd_q;
  logic [31:0]     wb_data_q;
  logic            misalign_exc_q;

  logic [31:0]     acc_addr_d;
  logic [31:0]     mem_addr_d;
  logic [31:0]     mem_wdata_d;
  logic [3:0]      mem_we_d;
  logic [31:0]     wb_data_d;
  logic            misaligned_d;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;

  // Lane placement of the incoming access; shifted-out bits are simply dropped.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can infer a latch.
    acc_addr_d  = bus.read ? bus.read_address : bus.write_address;
    mem_addr_d  = {acc_addr_d[31:2], 2'b00};
    mem_wdata_d = '0;
    mem_we_d    = '0;
    if (!bus.read) begin
      mem_wdata_d = bus.DATA_wb << {acc_addr_d[1:0], 3'b000};
      mem_we_d    = bus.we_mem << acc_addr_d[1:0];
    end
  end

`ifdef MISALIGN_CHECK_EN
  always_comb begin
    misaligned_d = 1'b0;
    case (bus.i)
      OP_LH, OP_LHU, OP_SH: misaligned_d = acc_addr_d[0];
      OP_LW, OP_SW:         misaligned_d = |acc_addr_d[1:0];
      default:              misaligned_d = 1'b0;
    endcase
  end
`else
  assign misaligned_d = 1'b0;
`endif

  // Returned word is narrowed using the offset latched at accept time.
  always_comb begin
    byte_sel = bus.mem_rdata[{off_q, 3'b000} +: 8];
    half_sel = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (op_q)
      OP_LB:   wb_data_d = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  wb_data_d = {24'h0, byte_sel};
      OP_LH:   wb_data_d = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  wb_data_d = {16'h0, half_sel};
      default: wb_data_d = bus.mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples the same pre-edge values.
    if (reset) begin
      state_q        <= S_IDLE;
      op_q           <= OP_LB;
      is_load_q      <= 1'b0;
      flushed_q      <= 1'b0;
      off_q          <= '0;
      rd_q           <= '0;
      mem_req_q      <= 1'b0;
      mem_addr_q     <= '0;
      mem_we_q       <= '0;
      mem_wdata_q    <= '0;
      wb_valid_q     <= 1'b0;
      wb_we_q        <= 1'b0;
      wb_rd_q        <= '0;
      wb_data_q      <= '0;
      misalign_exc_q <= 1'b0;
    end else begin
      wb_valid_q     <= 1'b0;
      misalign_exc_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (bus.in_valid && !bus.flush) begin
            if (misaligned_d) begin
              misalign_exc_q <= 1'b1;
            end else begin
              state_q     <= S_REQ;
              op_q        <= bus.i;
              is_load_q   <= bus.read;
              flushed_q   <= 1'b0;
              off_q       <= acc_addr_d[1:0];
              rd_q        <= bus.rd;
              mem_req_q   <= 1'b1;
              mem_addr_q  <= mem_addr_d;
              mem_we_q    <= mem_we_d;
              mem_wdata_q <= mem_wdata_d;
            end
          end
        end

        S_REQ: begin
          if (bus.mem_gnt) begin
            mem_req_q <= 1'b0;
            if (is_load_q) begin
              state_q   <= S_WAIT;
              flushed_q <= bus.flush;
            end else begin
              state_q <= S_IDLE;
              if (!bus.flush) begin
                wb_valid_q <= 1'b1;
                wb_we_q    <= 1'b0;
              end
            end
          end else if (bus.flush) begin
            // Not yet granted: the request is withdrawn as if never accepted.
            state_q   <= S_IDLE;
            mem_req_q <= 1'b0;
          end
        end

        S_WAIT: begin
          if (bus.flush) flushed_q <= 1'b1;
          if (bus.mem_rvalid) begin
            state_q <= S_IDLE;
            if (!(bus.flush || flushed_q)) begin
              wb_valid_q <= 1'b1;
              wb_we_q    <= (rd_q != 5'd0);
              wb_rd_q    <= rd_q;
              wb_data_q  <= wb_data_d;
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready     = (state_q == S_IDLE);
  assign bus.mem_req      = mem_req_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.wb_valid     = wb_valid_q;
  assign bus.wb_we        = wb_we_q;
  assign bus.wb_rd        = wb_rd_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.misalign_exc = misalign_exc_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: directed corner cases followed by randomized
// transactions compared against an arithmetic reference model.
module tb_lsu_mem_stage;
  import lsu_mem_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [31:0] exp_wb_data;
  logic [4:0]  exp_wb_rd;
  logic [31:0] got_wb_data;

  lsu_mem_stage_if bus ();

  lsu_mem_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_load(input logic [2:0] op);
    return op <= 3'd4;
  endfunction

  function automatic logic [3:0] size_mask(input logic [2:0] op);
    case (op)
      3'd7:    return 4'b0001;
      3'd6:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] op, input logic [31:0] addr,
                                             input logic [31:0] data);
    logic [63:0] w;
    if (is_load(op)) return 32'h0;
    w = {32'h0, data} << (8 * int'(addr[1:0]));
    return w[31:0];
  endfunction

  function automatic logic [3:0] ref_we(input logic [2:0] op, input logic [31:0] addr);
    logic [7:0] m;
    if (is_load(op)) return 4'h0;
    m = {4'h0, size_mask(op)} << addr[1:0];
    return m[3:0];
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr,
                                            input logic [31:0] w);
    int unsigned v;
    v = w >> (8 * int'(addr[1:0]));
    case (op)
      3'd0: begin v = v % 256;   if (v >= 128)   v = v + 32'hFFFF_FF00; end
      3'd1: v = v % 256;
      3'd2: begin v = v % 65536; if (v >= 32768) v = v + 32'hFFFF_0000; end
      3'd3: v = v % 65536;
      default: v = w;
    endcase
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    bus.in_valid      = 1'b0;
    bus.i             = OP_LB;
    bus.read          = 1'b0;
    bus.read_address  = '0;
    bus.write_address = '0;
    bus.DATA_wb       = '0;
    bus.we_mem        = '0;
    bus.rd            = '0;
    bus.flush         = 1'b0;
    bus.mem_gnt       = 1'b0;
    bus.mem_rvalid    = 1'b0;
    bus.mem_rdata     = '0;
  endtask

  // Garbage on the request fields once accepted: the stage must rely on its latched copy.
  task automatic scramble();
    bus.in_valid      = 1'b0;
    bus.i             = instruction_type'(3'($urandom));
    bus.read          = 1'($urandom);
    bus.read_address  = $urandom;
    bus.write_address = $urandom;
    bus.DATA_wb       = $urandom;
    bus.we_mem        = 4'($urandom);
    bus.rd            = 5'($urandom);
  endtask

  task automatic present(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input logic [4:0] rd);
    bus.in_valid = 1'b1;
    bus.i        = instruction_type'(op);
    bus.read     = is_load(op);
    bus.rd       = rd;
    if (is_load(op)) begin
      bus.read_address  = addr;
      bus.write_address = $urandom;
      bus.DATA_wb       = $urandom;
      bus.we_mem        = 4'($urandom);
    end else begin
      bus.write_address = addr;
      bus.read_address  = $urandom;
      bus.DATA_wb       = data;
      bus.we_mem        = size_mask(op);
    end
  endtask

  // Full transaction with bounded grant / read-data delays and stray bus events.
  task automatic do_txn(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input logic [4:0] rd, input int gnt_dly, input int rv_dly,
                        input logic [31:0] rdata);
    logic [31:0] e_addr, e_wd, e_ld;
    logic [3:0]  e_we;
    e_addr = {addr[31:2], 2'b00};
    e_wd   = ref_wdata(op, addr, data);
    e_we   = ref_we(op, addr);
    present(op, addr, data, rd);
    check("in_ready_before_accept", bus.in_ready, 1);
    tick();
    scramble();
    for (int k = 0; k <= gnt_dly; k++) begin
      check("req_mem_req", bus.mem_req, 1);
      check("req_mem_addr", bus.mem_addr, e_addr);
      check("req_mem_we", bus.mem_we, e_we);
      check("req_mem_wdata", bus.mem_wdata, e_wd);
      check("req_in_ready", bus.in_ready, 0);
      if (k < gnt_dly) begin
        bus.mem_rvalid = 1'($urandom);
        tick();
      end
    end
    bus.mem_rvalid = 1'b0;
    bus.mem_gnt    = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    if (!is_load(op)) begin
      check("st_wb_valid", bus.wb_valid, 1);
      check("st_wb_we", bus.wb_we, 0);
      check("st_in_ready", bus.in_ready, 1);
      tick();
      check("st_wb_pulse_end", bus.wb_valid, 0);
    end else begin
      for (int k = 0; k < rv_dly; k++) begin
        check("wait_mem_req", bus.mem_req, 0);
        check("wait_wb_valid", bus.wb_valid, 0);
        check("wait_in_ready", bus.in_ready, 0);
        bus.mem_gnt = 1'($urandom);
        tick();
      end
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = rdata;
      tick();
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = $urandom;
      e_ld        = ref_load(op, addr, rdata);
      exp_wb_data = e_ld;
      exp_wb_rd   = rd;
      got_wb_data = bus.wb_data;
      check("ld_wb_valid", bus.wb_valid, 1);
      check("ld_wb_data", bus.wb_data, e_ld);
      check("ld_wb_rd", bus.wb_rd, rd);
      check("ld_wb_we", bus.wb_we, (rd != 5'd0));
      check("ld_misalign_exc", bus.misalign_exc, 0);
      check("ld_in_ready", bus.in_ready, 1);
      tick();
      check("ld_wb_pulse_end", bus.wb_valid, 0);
      check("ld_wb_data_hold", bus.wb_data, e_ld);
    end
  endtask

  // ---------------- test sequence ----------------
  logic [2:0]  r_op;
  logic [31:0] r_addr, r_data;
  logic [4:0]  r_rd;

  initial begin
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_wb_valid", bus.wb_valid, 0);
    check("rst_wb_we", bus.wb_we, 0);
    check("rst_wb_rd", bus.wb_rd, 0);
    check("rst_wb_data", bus.wb_data, 0);
    check("rst_misalign_exc", bus.misalign_exc, 0);
    reset = 1'b0;
    tick();

    // LW with minimum latency
    do_txn(3'd4, 32'h0000_1000, 32'h0, 5'd5, 0, 0, 32'hDEAD_BEEF);
    check("lw_dir_data", got_wb_data, 32'hDEAD_BEEF);

    // LB / LBU from the top byte lane
    do_txn(3'd0, 32'h0000_1003, 32'h0, 5'd6, 0, 1, 32'h80FF_0000);
    check("lb_dir_data", got_wb_data, 32'hFFFF_FF80);
    do_txn(3'd1, 32'h0000_1003, 32'h0, 5'd6, 1, 0, 32'h80FF_0000);
    check("lbu_dir_data", got_wb_data, 32'h0000_0080);

    // SH to upper half with grant withheld for three cycles
    do_txn(3'd6, 32'h0000_2002, 32'h0000_ABCD, 5'd1, 3, 0, 32'h0);
    check("sh_dir_wdata", ref_wdata(3'd6, 32'h0000_2002, 32'h0000_ABCD) ^ bus.mem_wdata, 32'h0);

    // Load to x0 must not write
    do_txn(3'd4, 32'h0000_3000, 32'h0, 5'd0, 0, 0, 32'h1234_5678);

    // Flush while waiting for read data
    present(3'd2, 32'h0000_3002, 32'h0, 5'd7);
    tick();
    scramble();
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    bus.flush   = 1'b1;
    check("fw_in_ready_wait", bus.in_ready, 0);
    tick();
    bus.flush = 1'b0;
    check("fw_wb_valid_a", bus.wb_valid, 0);
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hCAFE_F00D;
    tick();
    bus.mem_rvalid = 1'b0;
    check("fw_wb_valid_b", bus.wb_valid, 0);
    check("fw_in_ready", bus.in_ready, 1);
    check("fw_wb_data_hold", bus.wb_data, exp_wb_data);
    check("fw_wb_rd_hold", bus.wb_rd, exp_wb_rd);
    tick();
    check("fw_wb_valid_c", bus.wb_valid, 0);

    // Flush in REQ before grant: request dropped, later grant ignored
    present(3'd5, 32'h0000_4000, 32'h1111_2222, 5'd2);
    tick();
    scramble();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("fr_in_ready", bus.in_ready, 1);
    check("fr_mem_req", bus.mem_req, 0);
    check("fr_wb_valid", bus.wb_valid, 0);
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    check("fr_stray_gnt_wb", bus.wb_valid, 0);
    check("fr_stray_gnt_req", bus.mem_req, 0);

    // Flush together with grant: store issued silently, load still waits for data
    present(3'd7, 32'h0000_4001, 32'h0000_00AA, 5'd2);
    tick();
    scramble();
    bus.mem_gnt = 1'b1;
    bus.flush   = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    bus.flush   = 1'b0;
    check("fgs_wb_valid", bus.wb_valid, 0);
    check("fgs_in_ready", bus.in_ready, 1);
    present(3'd1, 32'h0000_4002, 32'h0, 5'd3);
    tick();
    scramble();
    bus.mem_gnt = 1'b1;
    bus.flush   = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    bus.flush   = 1'b0;
    check("fgl_mem_req", bus.mem_req, 0);
    check("fgl_in_ready_wait", bus.in_ready, 0);
    bus.mem_rvalid = 1'b1;
    tick();
    bus.mem_rvalid = 1'b0;
    check("fgl_wb_valid", bus.wb_valid, 0);
    check("fgl_in_ready", bus.in_ready, 1);

    // Flush in IDLE blocks acceptance
    present(3'd4, 32'h0000_5000, 32'h0, 5'd4);
    bus.flush = 1'b1;
    tick();
    scramble();
    bus.flush = 1'b0;
    check("fi_mem_req", bus.mem_req, 0);
    check("fi_in_ready", bus.in_ready, 1);

    // Reset in WAIT abandons the load; later rvalid/gnt are ignored
    present(3'd4, 32'h0000_6000, 32'h0, 5'd9);
    tick();
    scramble();
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_wb_data = 32'h0;
    exp_wb_rd   = 5'd0;
    check("rw_in_ready", bus.in_ready, 1);
    check("rw_mem_req", bus.mem_req, 0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hFFFF_FFFF;
    tick();
    bus.mem_rvalid = 1'b0;
    check("rw_stray_rvalid_wb", bus.wb_valid, 0);
    check("rw_stray_in_ready", bus.in_ready, 1);
    check("rw_wb_data", bus.wb_data, exp_wb_data);
    tick();
    check("rw_wb_valid_late", bus.wb_valid, 0);

`ifdef MISALIGN_CHECK_EN
    present(3'd4, 32'h0000_1001, 32'h0, 5'd3);
    tick();
    scramble();
    check("ma_lw_mem_req", bus.mem_req, 0);
    check("ma_lw_exc", bus.misalign_exc, 1);
    check("ma_lw_in_ready", bus.in_ready, 1);
    tick();
    check("ma_lw_exc_end", bus.misalign_exc, 0);
    check("ma_lw_mem_req_b", bus.mem_req, 0);
    check("ma_lw_wb_valid", bus.wb_valid, 0);
    present(3'd6, 32'h0000_2001, 32'h0000_1234, 5'd3);
    tick();
    scramble();
    check("ma_sh_exc", bus.misalign_exc, 1);
    check("ma_sh_mem_req", bus.mem_req, 0);
    tick();
    check("ma_sh_exc_end", bus.misalign_exc, 0);
`else
    do_txn(3'd4, 32'h0000_1001, 32'h0, 5'd3, 0, 0, 32'h0BAD_F00D);
    check("ma_off_exc", bus.misalign_exc, 0);
    do_txn(3'd5, 32'h0000_1003, 32'h8765_4321, 5'd3, 1, 0, 32'h0);
`endif

    // Randomized transactions
    for (int t = 0; t < 80; t++) begin
      r_op   = 3'($urandom_range(0, 7));
      r_addr = $urandom;
`ifdef MISALIGN_CHECK_EN
      if (r_op inside {3'd2, 3'd3, 3'd6}) r_addr[0] = 1'b0;
      if (r_op inside {3'd4, 3'd5})       r_addr[1:0] = 2'b00;
`else
      if (r_op inside {3'd2, 3'd3})       r_addr[0] = 1'b0;
`endif
      r_data = $urandom;
      if (r_op == 3'd7) r_data = r_data & 32'h0000_00FF;
      if (r_op == 3'd6) r_data = r_data & 32'h0000_FFFF;
      r_rd = 5'($urandom);
      if ($urandom_range(0, 7) == 0) r_rd = 5'd0;
      do_txn(r_op, r_addr, r_data, r_rd, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      if ($urandom_range(0, 3) == 0) tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_mem_stage.md
LSU_MEM_STAGE -- requirements
Module: lsu_mem_stage

Interface
REQ-001 clk  input  1  sole clock, all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 in_valid  input  1  execute stage presents a load/store this cycle.
REQ-004 in_ready  output  1  stage can accept; high only in IDLE.
REQ-005 i  input  instruction_type  OP0 LB, OP1 LBU, OP2 LH, OP3 LHU, OP4 LW, OP5 SW, OP6 SH, OP7 SB.
REQ-006 read  input  1  load indicator from LSUnit.
REQ-007 read_address, write_address  input  32 each  load/store effective address.
REQ-008 DATA_wb  input  32  store data, right-justified, upper bits zero.
REQ-009 we_mem  input  4  store size mask, right-justified (0001/0011/1111).
REQ-010 rd  input  5  destination register.
REQ-011 flush  input  1  squash the in-flight operation.
REQ-012 mem_req  output  1  bus request; mem_addr output 32; mem_we output 4; mem_wdata output 32.
REQ-013 mem_gnt  input  1  bus accepted request; mem_rvalid input 1; mem_rdata input 32.
REQ-014 wb_valid  output  1  one-cycle completion pulse; wb_we output 1; wb_rd output 5; wb_data output 32.
REQ-015 misalign_exc  output  1  one-cycle misaligned-access pulse (only with MISALIGN_CHECK_EN).

Function
REQ-016 FSM states: IDLE, REQ, WAIT; in_ready = (state==IDLE).
REQ-017 IDLE: on in_valid, latch op, address (read ? read_address : write_address), rd, aligned data/mask; next state REQ.
REQ-018 Store alignment: mem_wdata = DATA_wb << 8*addr[1:0]; mem_we = we_mem << addr[1:0]; mem_addr = {addr[31:2],2'b00}.
REQ-019 Loads: mem_we = 0000, mem_wdata = 0, same word-aligned mem_addr.
REQ-020 REQ: mem_req=1, outputs stable until mem_gnt; on gnt store -> IDLE with wb_valid=1, wb_we=0 next cycle; load -> WAIT.
REQ-021 WAIT: mem_req=0; on mem_rvalid -> IDLE, next cycle wb_valid=1, wb_we=1 (0 if rd==0), wb_rd=latched rd.
REQ-022 Load data: select byte/half by latched addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW whole word.
REQ-023 Minimum latency: accept cycle N, mem_req N+1; store wb_valid N+2; load wb_valid N+3 with rvalid at N+2.
REQ-024 mem_rvalid in IDLE/REQ ignored; mem_gnt outside REQ ignored.
REQ-025 flush in REQ with mem_gnt=0: drop request, -> IDLE, no wb_valid.
REQ-026 flush in REQ with mem_gnt=1, or in WAIT: load continues to rvalid, wb_valid suppressed; store counts as issued, wb_valid suppressed.
REQ-027 flush in IDLE with in_valid=1: request not accepted.
REQ-028 wb_valid/misalign_exc high exactly one cycle; wb_data/wb_rd hold last values between pulses.

Reset
REQ-029 reset -> IDLE; mem_req, mem_we, wb_valid, wb_we, misalign_exc = 0; mem_addr, mem_wdata, wb_data, wb_rd = 0.
REQ-030 reset mid-transaction abandons it; later rvalid/gnt ignored until a new request is accepted.

Configuration
REQ-031 Macro MISALIGN_CHECK_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=0 accepted in IDLE, no bus request, misalign_exc=1 next cycle, stays IDLE, no wb_valid.
REQ-032 Macro MISALIGN_CHECK_EN undefined: no check; misalign_exc tied 0; shifted mask/data truncated to 32/4 bits.

Verification
REQ-033 LW 0x0000_1000, gnt N+1, rvalid N+2 rdata 0xDEADBEEF, rd=5 -> wb_valid N+3, wb_data 0xDEADBEEF, wb_rd 5, wb_we 1.
REQ-034 LB addr 0x1003, rdata 0x80FF_0000 -> wb_data 0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-035 SH addr 0x2002 DATA_wb 0x0000_ABCD -> mem_addr 0x2000, mem_we 1100, mem_wdata 0xABCD_0000; gnt held low 3 cycles -> outputs stable, then wb_valid wb_we=0.
REQ-036 LH in WAIT with flush=1, rvalid two cycles later -> no wb_valid, in_ready 1 after rvalid.
REQ-037 MISALIGN_CHECK_EN: LW addr 0x1001 -> mem_req stays 0, misalign_exc pulse next cycle; undefined -> mem_addr 0x1000.
REQ-038 reset asserted in WAIT, stray rvalid after -> wb_valid stays 0, in_ready 1.
